instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have a parameter NOP_INSTR, default 32'h0000_0013, giving the Instr value held while no valid instruction is present.
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
REQ-005 PCSrc  input  2  next-PC select from the controller: 00 = PC+4, 01 = PC+ImmExt, 10 = {ALUResult[31:1],1'b0}, 11 = hold.
REQ-006 ImmExt  input  32  branch/jal offset from the datapath.
REQ-007 ALUResult  input  32  jalr target from the datapath.
REQ-008 instr_ack  input  1  datapath has retired the current Instr this cycle.
REQ-009 mem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-010 mem_addr  output  32  read address, equal to PC.
REQ-011 mem_rvalid  input  1  read data valid.
REQ-012 mem_rdata  input  32  read data.
REQ-013 Instr  output  32  current instruction to the datapath/controller.
REQ-014 PC  output  32  address of Instr.
REQ-015 PCPlus4  output  32  PC+4, combinational from PC, for jal/jalr link.
REQ-016 instr_valid  output  1  Instr is valid and awaiting instr_ack.
REQ-017 misaligned  output  1  sticky fault: a computed target had bits [1:0] != 00.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, WAIT, VALID and HALT.
REQ-019 IDLE SHALL go to FETCH on the first rising edge after rst deasserts.
REQ-020 FETCH SHALL assert mem_req=1 with mem_addr=PC for exactly one cycle, then go to WAIT; mem_req SHALL be 0 in every other state.
REQ-021 WAIT SHALL sample mem_rvalid only; on mem_rvalid=1 it SHALL capture mem_rdata into Instr and go to VALID; otherwise it SHALL stay in WAIT indefinitely.
REQ-022 mem_rvalid asserted in any state other than WAIT SHALL be ignored, with no change to Instr or state.
REQ-023 instr_valid SHALL be 1 exactly while in VALID.
REQ-024 In VALID with instr_ack=0, the block SHALL hold state, PC and Instr.
REQ-025 In VALID with instr_ack=1 and PCSrc=11, the block SHALL hold state, PC and Instr.
REQ-026 In VALID with instr_ack=1 and PCSrc in {00,01,10}, the block SHALL compute the target; if target[1:0]=00 it SHALL load PC with the target, set Instr=NOP_INSTR and go to FETCH.
REQ-027 If the target in REQ-026 has target[1:0]!=00, the block SHALL set misaligned=1, leave PC unchanged and go to HALT.
REQ-028 HALT SHALL be left only by reset; the block SHALL issue no requests there, with instr_valid=0.
REQ-029 All target arithmetic SHALL be 32-bit modulo 2^32: PC+4 at 32'hFFFF_FFFC yields 0, and negative ImmExt is two's-complement.
REQ-030 PCSrc=10 SHALL clear bit 0 before the alignment check, so ALUResult=...01 yields no fault, while ...10 faults.
REQ-031 Minimum per-instruction latency SHALL be 3 cycles (FETCH, WAIT with rvalid, VALID with ack); each WAIT stall cycle SHALL add exactly one cycle.
REQ-032 At most one memory request SHALL be outstanding at any time.
REQ-033 PC, Instr, instr_valid, misaligned and mem_req SHALL be registered outputs.

Reset
REQ-034 On rst=0 the block SHALL, asynchronously, set state=IDLE, PC=RESET_PC, Instr=NOP_INSTR, instr_valid=0, mem_req=0 and misaligned=0.
REQ-035 Reset asserted in any state, including WAIT with a read outstanding, SHALL abort the operation; any mem_rvalid before the next FETCH SHALL be discarded.

Verification
REQ-036 Scenario: reset release, mem_rvalid one cycle after mem_req with rdata=32'h00500093, ack with PCSrc=00 -> mem_req at addr 0; Instr=32'h00500093, instr_valid=1; second mem_req at addr 4.
REQ-037 Scenario: PC=32'h10, PCSrc=01, ImmExt=32'hFFFF_FFF8, ack -> next mem_addr=32'h08.
REQ-038 Scenario: PCSrc=10, ALUResult=32'h0000_0101, ack -> mem_addr=32'h100, misaligned=0; then ALUResult=32'h0000_0102, ack -> misaligned=1, state HALT, no further mem_req.
REQ-039 Scenario: mem_rvalid held 0 for 5 WAIT cycles -> instr_valid=0 throughout; rvalid on cycle 6 -> Instr captured, instr_valid=1.
REQ-040 Scenario: rst=0 mid-WAIT, then a stray mem_rvalid after release -> PC=RESET_PC, Instr=NOP_INSTR, stray data ignored, fresh fetch at RESET_PC.
REQ-041 Scenario: PC=32'hFFFF_FFFC, PCSrc=00, ack -> mem_addr=32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with PC sequencing.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   PCSrc[1:0]   next-PC select: 00 PC+4, 01 PC+ImmExt, 10 ALUResult & ~1, 11 hold
//   ImmExt[31:0] branch/jal offset
//   ALUResult    jalr target
//   instr_ack    datapath retires the current Instr this cycle
//   mem_req      one-cycle instruction-memory read request (registered)
//   mem_addr     read address, equal to PC
//   mem_rvalid   read data valid (only honoured while waiting for data)
//   mem_rdata    read data
//   Instr        current instruction (registered)
//   PC           address of Instr (registered)
//   PCPlus4      PC+4, combinational link value
//   instr_valid  Instr valid and awaiting instr_ack (registered)
//   misaligned   sticky fault: a computed target was not word aligned
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        instr_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        VALID,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] target;
    logic        redirect;
    logic        fault;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic        misaligned_next;
    logic        mem_req_next;
    logic        instr_valid_next;

    assign PCPlus4  = PC + 32'd4;
    assign mem_addr = PC;

    // jalr target has bit 0 cleared before the alignment check
    always_comb begin
        case (PCSrc)
            2'b00:   target = PCPlus4;
            2'b01:   target = PC + ImmExt;
            2'b10:   target = ALUResult & ~32'd1;
            default: target = PC;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        redirect   = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: state_next = WAIT;
            WAIT:  if (mem_rvalid) state_next = VALID;
            VALID: begin
                if (instr_ack && (PCSrc != 2'b11)) begin
                    if (target[1:0] == 2'b00) begin
                        redirect   = 1'b1;
                        state_next = FETCH;
                    end else begin
                        fault      = 1'b1;
                        state_next = HALT;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    // mem_req/instr_valid are registered from state_next so they coincide
    // exactly with residence in FETCH/VALID.
    always_comb begin
        pc_next          = PC;
        instr_next       = Instr;
        misaligned_next  = misaligned;
        if ((state == WAIT) && mem_rvalid) begin
            instr_next = mem_rdata;
        end
        if (redirect) begin
            pc_next    = target;
            instr_next = NOP_INSTR;
        end
        if (fault) begin
            misaligned_next = 1'b1;
        end
        mem_req_next     = (state_next == FETCH);
        instr_valid_next = (state_next == VALID);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC          <= RESET_PC;
            Instr       <= NOP_INSTR;
            misaligned  <= 1'b0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            PC          <= pc_next;
            Instr       <= instr_next;
            misaligned  <= misaligned_next;
            mem_req     <= mem_req_next;
            instr_valid <= instr_valid_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        instr_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misaligned;

    int unsigned vectors;
    int unsigned miscompares;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc      (PCSrc),
        .ImmExt     (ImmExt),
        .ALUResult  (ALUResult),
        .instr_ack  (instr_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .Instr      (Instr),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .instr_valid(instr_valid),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From FETCH: leave FETCH, stall for 'stall' WAIT cycles, then deliver data.
    task automatic fetch_instr(input logic [31:0] data, input int unsigned stall);
        tick();
        check("wait_req", {31'd0, mem_req}, 32'd0);
        check("wait_valid", {31'd0, instr_valid}, 32'd0);
        for (int unsigned i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
            check("stall_req", {31'd0, mem_req}, 32'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        check("cap_valid", {31'd0, instr_valid}, 32'd1);
        check("cap_instr", Instr, data);
    endtask

    // From VALID: acknowledge with a redirect that must be aligned.
    task automatic ack_redirect(input logic [1:0] src, input logic [31:0] imm,
                                input logic [31:0] alu, input logic [31:0] exp_pc);
        instr_ack = 1'b1;
        PCSrc     = src;
        ImmExt    = imm;
        ALUResult = alu;
        tick();
        instr_ack = 1'b0;
        PCSrc     = 2'b11;
        check("redir_req", {31'd0, mem_req}, 32'd1);
        check("redir_addr", mem_addr, exp_pc);
        check("redir_pc", PC, exp_pc);
        check("redir_instr", Instr, NOP);
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_mis", {31'd0, misaligned}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        PCSrc       = 2'b11;
        ImmExt      = '0;
        ALUResult   = '0;
        instr_ack   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        // Reset state held across edges
        tick();
        tick();
        check("rst_pc", PC, RST_PC);
        check("rst_instr", Instr, NOP);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_pcplus4", PCPlus4, 32'd4);

        // First fetch at address 0
        rst = 1'b1;
        tick();
        check("f0_req", {31'd0, mem_req}, 32'd1);
        check("f0_addr", mem_addr, 32'h0);
        // rvalid during FETCH must be ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("f0_stray_instr", Instr, NOP);
        check("f0_wait_req", {31'd0, mem_req}, 32'd0);
        check("f0_wait_valid", {31'd0, instr_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0050_0093;
        tick();
        mem_rvalid = 1'b0;
        check("f0_instr", Instr, 32'h0050_0093);
        check("f0_valid", {31'd0, instr_valid}, 32'd1);
        check("f0_vreq", {31'd0, mem_req}, 32'd0);

        // Hold without ack, and with ack + PCSrc=11
        tick();
        check("hold_noack_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_noack_pc", PC, 32'h0);
        instr_ack = 1'b1;
        PCSrc     = 2'b11;
        tick();
        instr_ack = 1'b0;
        check("hold_11_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_11_instr", Instr, 32'h0050_0093);
        check("hold_11_req", {31'd0, mem_req}, 32'd0);

        // Sequential advance to 4
        ack_redirect(2'b00, 32'h0, 32'h0, 32'h4);
        check("pcplus4_at4", PCPlus4, 32'h8);

        // Five stall cycles, data on the sixth
        fetch_instr(32'h0100_0067, 5);

        // jalr to 0x11 -> bit 0 cleared -> 0x10
        ack_redirect(2'b10, 32'h0, 32'h0000_0011, 32'h10);

        // Negative branch offset: 0x10 - 8 = 0x08
        fetch_instr(32'h1111_1111, 0);
        ack_redirect(2'b01, 32'hFFFF_FFF8, 32'h0, 32'h08);

        // jalr ALUResult=0x101 -> 0x100, no fault
        fetch_instr(32'h2222_2222, 0);
        ack_redirect(2'b10, 32'h0, 32'h0000_0101, 32'h100);

        // 0x100 + 0xFFFFFEFC = 0xFFFFFFFC
        fetch_instr(32'h3333_3333, 1);
        ack_redirect(2'b01, 32'hFFFF_FEFC, 32'h0, 32'hFFFF_FFFC);
        check("pcplus4_wrap", PCPlus4, 32'h0);

        // PC+4 wraps to 0
        fetch_instr(32'h4444_4444, 0);
        ack_redirect(2'b00, 32'h0, 32'h0, 32'h0);

        // jalr ALUResult=0x102 -> misaligned, HALT
        fetch_instr(32'h5555_5555, 0);
        instr_ack = 1'b1;
        PCSrc     = 2'b10;
        ALUResult = 32'h0000_0102;
        tick();
        instr_ack = 1'b0;
        PCSrc     = 2'b11;
        check("halt_mis", {31'd0, misaligned}, 32'd1);
        check("halt_pc", PC, 32'h0);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_req", {31'd0, mem_req}, 32'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            instr_ack  = 1'b1;
            PCSrc      = 2'b00;
            tick();
            check("halt_stay_req", {31'd0, mem_req}, 32'd0);
            check("halt_stay_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_stay_mis", {31'd0, misaligned}, 32'd1);
        end
        mem_rvalid = 1'b0;
        instr_ack  = 1'b0;
        PCSrc      = 2'b11;

        // Asynchronous reset out of HALT, between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_halt_mis", {31'd0, misaligned}, 32'd0);
        check("arst_halt_pc", PC, RST_PC);
        tick();
        rst = 1'b1;

        // Reset mid-WAIT with PC nonzero, then stray rvalid
        tick();
        check("r2_req", {31'd0, mem_req}, 32'd1);
        fetch_instr(32'h6666_6666, 0);
        ack_redirect(2'b00, 32'h0, 32'h0, 32'h4);
        tick();
        check("r2_wait_pc", PC, 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wait_pc", PC, RST_PC);
        check("arst_wait_instr", Instr, NOP);
        check("arst_wait_req", {31'd0, mem_req}, 32'd0);
        check("arst_wait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        // Stray data arrives across the IDLE and FETCH edges after release
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        check("r3_req", {31'd0, mem_req}, 32'd1);
        check("r3_addr", mem_addr, RST_PC);
        check("r3_instr", Instr, NOP);
        tick();
        mem_rvalid = 1'b0;
        check("r3_stray_instr", Instr, NOP);
        check("r3_stray_valid", {31'd0, instr_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0080_0113;
        tick();
        mem_rvalid = 1'b0;
        check("r3_instr_cap", Instr, 32'h0080_0113);
        check("r3_valid", {31'd0, instr_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
